// File: rtl/dds_ctrl_pkg.sv
// Shared encodings and default widths for the DDS frequency sweep controller.
package dds_ctrl_pkg;

  localparam int unsigned FW_DEF = 24;
  localparam int unsigned DW_DEF = 16;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  function automatic logic mode_supported(input logic [1:0] m);
    return (m != MODE_RSVD);
  endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter; expire is high while the count reads zero.
module dds_dwell_timer #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] load_val,
  output logic          expire
);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear DDS frequency sweep sequencer (single-shot, sawtooth, triangle)
// with an atomically latched shadow configuration.
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned FW = FW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [FW-1:0] cfg_start,
  input  logic [FW-1:0] cfg_stop,
  input  logic [FW-1:0] cfg_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [1:0]    cfg_mode,
  output logic          cfg_err,
  input  logic          start,
  input  logic          abort,
  output logic [FW-1:0] fre_dat,
  output logic          fre_upd,
  output logic          dds_en,
  output logic          busy,
  output logic          done
);

  state_t        state;
  dir_t          dir;

  logic [FW-1:0] sh_start, sh_stop, sh_step;
  logic [DW-1:0] sh_dwell;
  mode_t         sh_mode;
  logic          sh_valid;

  // Working copy taken at start, so a config accepted alongside start
  // only affects the following sweep.
  logic [FW-1:0] ac_start, ac_stop, ac_step;
  logic [DW-1:0] ac_dwell;
  mode_t         ac_mode;

  logic          cfg_bad;
  logic          start_go;
  logic          tmr_load;
  logic          tmr_expire;
  logic [DW-1:0] tmr_val;

  logic [FW:0]   sum;
  logic [FW:0]   diff;
  logic [FW-1:0] up_val;
  logic [FW-1:0] dn_val;
  logic [FW-1:0] nxt_val;
  dir_t          nxt_dir;
  logic          sweep_end;

  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN);

  assign cfg_bad  = (cfg_step == '0) || (cfg_start > cfg_stop) ||
                    !mode_supported(cfg_mode);
  assign start_go = (state == ST_IDLE) && start && sh_valid && !abort;

  assign tmr_load = start_go || ((state == ST_RUN) && tmr_expire && !abort);
  assign tmr_val  = (state == ST_IDLE) ? sh_dwell : ac_dwell;

  dds_dwell_timer #(
    .DW(DW)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (state == ST_RUN),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // One extra bit exposes carry/borrow so the clamp never sees a wrapped value.
  assign sum    = {1'b0, fre_dat} + {1'b0, ac_step};
  assign diff   = {1'b0, fre_dat} - {1'b0, ac_step};
  assign up_val = (sum[FW]  || (sum[FW-1:0]  >= ac_stop))  ? ac_stop  : sum[FW-1:0];
  assign dn_val = (diff[FW] || (diff[FW-1:0] <= ac_start)) ? ac_start : diff[FW-1:0];

  always_comb begin
    nxt_val   = fre_dat;
    nxt_dir   = dir;
    sweep_end = 1'b0;
    if (dir == DIR_UP) begin
      if (fre_dat == ac_stop) begin
        case (ac_mode)
          MODE_SAW: nxt_val = ac_start;
          MODE_TRI: begin
            nxt_dir = DIR_DOWN;
            nxt_val = dn_val;
          end
          default:  sweep_end = 1'b1;
        endcase
      end else begin
        nxt_val = up_val;
      end
    end else if (fre_dat == ac_start) begin
      nxt_dir = DIR_UP;
      nxt_val = up_val;
    end else begin
      nxt_val = dn_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      dir      <= DIR_UP;
      fre_dat  <= '0;
      fre_upd  <= 1'b0;
      dds_en   <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      sh_start <= '0;
      sh_stop  <= '0;
      sh_step  <= '0;
      sh_dwell <= '0;
      sh_mode  <= MODE_SINGLE;
      sh_valid <= 1'b0;
      ac_start <= '0;
      ac_stop  <= '0;
      ac_step  <= '0;
      ac_dwell <= '0;
      ac_mode  <= MODE_SINGLE;
    end else begin
      fre_upd <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;

      if ((state == ST_IDLE) && cfg_valid) begin
        if (cfg_bad) begin
          cfg_err <= 1'b1;
        end else begin
          sh_start <= cfg_start;
          sh_stop  <= cfg_stop;
          sh_step  <= cfg_step;
          sh_dwell <= cfg_dwell;
          sh_mode  <= mode_t'(cfg_mode);
          sh_valid <= 1'b1;
        end
      end

      if (abort) begin
        state  <= ST_IDLE;
        dds_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_go) begin
              state    <= ST_RUN;
              dir      <= DIR_UP;
              fre_dat  <= sh_start;
              fre_upd  <= 1'b1;
              dds_en   <= 1'b1;
              ac_start <= sh_start;
              ac_stop  <= sh_stop;
              ac_step  <= sh_step;
              ac_dwell <= sh_dwell;
              ac_mode  <= sh_mode;
            end
          end
          ST_RUN: begin
            if (tmr_expire) begin
              if (sweep_end) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end else begin
                fre_dat <= nxt_val;
                dir     <= nxt_dir;
                fre_upd <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: table of sweep configurations with
// hand-computed frequency sequences, checked through an update scoreboard.
module tb_dds_sweep_ctrl;

  localparam int FW = 24;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [FW-1:0] cfg_start, cfg_stop, cfg_step;
  logic [DW-1:0] cfg_dwell;
  logic [1:0]    cfg_mode;
  logic          cfg_err;
  logic          start;
  logic          abort;
  logic [FW-1:0] fre_dat;
  logic          fre_upd;
  logic          dds_en;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(
    .FW(FW),
    .DW(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .cfg_step  (cfg_step),
    .cfg_dwell (cfg_dwell),
    .cfg_mode  (cfg_mode),
    .cfg_err   (cfg_err),
    .start     (start),
    .abort     (abort),
    .fre_dat   (fre_dat),
    .fre_upd   (fre_upd),
    .dds_en    (dds_en),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [FW-1:0]        start_f;
    logic [FW-1:0]        stop_f;
    logic [FW-1:0]        step_f;
    logic [DW-1:0]        dwell;
    logic [1:0]           mode;
    logic                 exp_err;
    logic                 exp_done;
    int                   gap;
    int                   n;
    logic [7:0][FW-1:0]   seq;
  } vec_t;

  vec_t vecs[11];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [FW-1:0] exp_q[$];
  int  cyc = 0;
  bit  have_last;
  int  last_upd, first_upd, done_cnt, done_cyc, exp_gap;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [FW-1:0] s, input logic [FW-1:0] e,
                              input logic [FW-1:0] st, input logic [DW-1:0] dw,
                              input logic [1:0] m, input logic err, input logic dn,
                              input int n,
                              input logic [FW-1:0] s0, input logic [FW-1:0] s1,
                              input logic [FW-1:0] s2, input logic [FW-1:0] s3,
                              input logic [FW-1:0] s4, input logic [FW-1:0] s5,
                              input logic [FW-1:0] s6, input logic [FW-1:0] s7);
    vec_t v;
    v.start_f = s;  v.stop_f = e;  v.step_f = st;  v.dwell = dw;
    v.mode = m;  v.exp_err = err;  v.exp_done = dn;
    v.gap = int'(dw) + 1;
    v.n = n;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3;
    v.seq[4] = s4; v.seq[5] = s5; v.seq[6] = s6; v.seq[7] = s7;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every fre_upd pulse consumes one expected frequency word.
  always @(negedge clk) begin
    if (!rst) begin
      if (fre_upd) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_upd: got fre_upd with fre_dat=%0h, required no update (cycle %0d)",
                   fre_dat, cyc);
        end else begin
          check("fre_dat", fre_dat, exp_q.pop_front());
        end
        check("upd_busy_en", {busy, dds_en}, 2'b11);
        if (have_last) check("dwell_gap", cyc - last_upd, exp_gap);
        else first_upd = cyc;
        have_last = 1'b1;
        last_upd  = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drive_cfg(input vec_t v);
    cfg_start = v.start_f;
    cfg_stop  = v.stop_f;
    cfg_step  = v.step_f;
    cfg_dwell = v.dwell;
    cfg_mode  = v.mode;
  endtask

  task automatic send_cfg(input vec_t v);
    drive_cfg(v);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("cfg_err", cfg_err, v.exp_err);
    step();
    check("cfg_err_pulse", cfg_err, 0);
  endtask

  task automatic arm(input vec_t v, input int n);
    have_last = 1'b0;
    exp_gap   = v.gap;
    done_cnt  = 0;
    for (int i = 0; i < n; i++) exp_q.push_back(v.seq[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check("sb_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic finish_vec(input vec_t v);
    drain(400);
    if (v.exp_done) begin
      step(v.gap + 1);
      check("done_cnt", done_cnt, 1);
      check("done_time", done_cyc - first_upd, v.n * v.gap);
      check("busy_after_done", busy, 0);
      check("dds_en_after_done", dds_en, 1);
      check("fre_dat_hold", fre_dat, v.seq[v.n-1]);
    end else begin
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_dds_en", dds_en, 0);
      check("abort_fre_dat", fre_dat, v.seq[v.n-1]);
      check("abort_no_done", done_cnt, 0);
      step(3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(24'd100, 24'd130, 24'd10, 16'd2, 2'd0, 1'b0, 1'b1, 4,
                  24'd100, 24'd110, 24'd120, 24'd130, 24'd0, 24'd0, 24'd0, 24'd0);
    vecs[1]  = mk(24'd0, 24'd25, 24'd10, 16'd0, 2'd0, 1'b0, 1'b1, 4,
                  24'd0, 24'd10, 24'd20, 24'd25, 24'd0, 24'd0, 24'd0, 24'd0);
    vecs[2]  = mk(24'd100, 24'd120, 24'd10, 16'd0, 2'd2, 1'b0, 1'b0, 7,
                  24'd100, 24'd110, 24'd120, 24'd110, 24'd100, 24'd110, 24'd120, 24'd0);
    vecs[3]  = mk(24'd100, 24'd120, 24'd10, 16'd0, 2'd1, 1'b0, 1'b0, 5,
                  24'd100, 24'd110, 24'd120, 24'd100, 24'd110, 24'd0, 24'd0, 24'd0);
    vecs[4]  = mk(24'hFFFFF0, 24'hFFFFFF, 24'h20, 16'd0, 2'd0, 1'b0, 1'b1, 2,
                  24'hFFFFF0, 24'hFFFFFF, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0);
    vecs[5]  = mk(24'd5, 24'd17, 24'd5, 16'd1, 2'd2, 1'b0, 1'b0, 8,
                  24'd5, 24'd10, 24'd15, 24'd17, 24'd12, 24'd7, 24'd5, 24'd10);
    vecs[6]  = mk(24'd50, 24'd50, 24'd3, 16'd1, 2'd1, 1'b0, 1'b0, 4,
                  24'd50, 24'd50, 24'd50, 24'd50, 24'd0, 24'd0, 24'd0, 24'd0);
    vecs[7]  = mk(24'd50, 24'd50, 24'd3, 16'd3, 2'd0, 1'b0, 1'b1, 1,
                  24'd50, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0);
    // Rejected configs: the expected sweep is the one kept from vecs[7].
    vecs[8]  = mk(24'd200, 24'd100, 24'd10, 16'd0, 2'd0, 1'b1, 1'b1, 1,
                  24'd50, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0);
    vecs[9]  = mk(24'd10, 24'd100, 24'd0, 16'd0, 2'd1, 1'b1, 1'b1, 1,
                  24'd50, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0);
    vecs[10] = mk(24'd10, 24'd100, 24'd5, 16'd0, 2'd3, 1'b1, 1'b1, 1,
                  24'd50, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0);
    for (int i = 8; i < 11; i++) vecs[i].gap = vecs[7].gap;

    rst = 1'b1;  cfg_valid = 1'b0;  start = 1'b0;  abort = 1'b0;
    cfg_start = '0;  cfg_stop = '0;  cfg_step = '0;  cfg_dwell = '0;  cfg_mode = '0;
    have_last = 1'b0;  exp_gap = 1;  done_cnt = 0;
    step(2);
    check("rst_fre_dat", fre_dat, 0);
    check("rst_fre_upd", fre_upd, 0);
    check("rst_outs", {dds_en, busy, done, cfg_err}, 0);
    rst = 1'b0;
    step();
    check("idle_cfg_ready", cfg_ready, 1);

    pulse_start();
    step(3);
    check("start_no_cfg_busy", busy, 0);
    check("start_no_cfg_en", dds_en, 0);

    for (int i = 0; i < 11; i++) begin
      send_cfg(vecs[i]);
      arm(vecs[i], vecs[i].n);
      pulse_start();
      finish_vec(vecs[i]);
    end

    // cfg_valid with start: the sweep uses the old shadow (vecs[7]).
    arm(vecs[7], vecs[7].n);
    drive_cfg(vecs[0]);
    cfg_valid = 1'b1;
    start     = 1'b1;
    step();
    cfg_valid = 1'b0;
    start     = 1'b0;
    check("cfg_with_start_err", cfg_err, 0);
    finish_vec(vecs[7]);
    arm(vecs[0], vecs[0].n);
    pulse_start();
    finish_vec(vecs[0]);

    // Abort on the 5th cycle of the first sweep.
    arm(vecs[0], 2);
    pulse_start();
    step(4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort5_busy", busy, 0);
    check("abort5_en", dds_en, 0);
    check("abort5_fre_dat", fre_dat, 110);
    check("abort5_no_done", done_cnt, 0);
    check("abort5_sb", exp_q.size(), 0);
    step(3);

    // Restart after abort, with a stray start mid-run that must be ignored.
    arm(vecs[0], vecs[0].n);
    pulse_start();
    step(2);
    start = 1'b1;
    step();
    start = 1'b0;
    finish_vec(vecs[0]);

    // Reset mid-sweep: async clear and loss of the shadow configuration.
    send_cfg(vecs[3]);
    arm(vecs[3], vecs[3].n);
    pulse_start();
    step(2);
    rst = 1'b1;
    #1;
    check("midrst_fre_dat", fre_dat, 0);
    check("midrst_outs", {fre_upd, dds_en, busy, done, cfg_err}, 0);
    check("midrst_cfg_ready", cfg_ready, 1);
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    pulse_start();
    step(3);
    check("post_rst_start_busy", busy, 0);
    check("post_rst_start_en", dds_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Sequences the DDS frequency word over time. It performs linear frequency sweeps (single-shot, sawtooth repeat or triangle) from a configured start to a stop frequency in fixed steps.
- It sits between the SPI register bank and the DDS output stage. It drives that stage's 24-bit frequency word and its output-enable (the SPI_OK-style gate).
- Configuration is latched atomically through a valid/ready handshake, so a sweep never runs on half-written parameters.

Parameters:
- FW, 24, frequency word width (matches the DDS fre_dat input).
- DW, 16, dwell counter width.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  configuration fields are valid this cycle.
- cfg_ready  out  1  controller accepts configuration (high only in IDLE).
- cfg_start  in  FW  sweep start frequency word.
- cfg_stop  in  FW  sweep stop frequency word.
- cfg_step  in  FW  increment per step.
- cfg_dwell  in  DW  extra hold cycles per frequency value.
- cfg_mode  in  2  0 = single-shot up, 1 = sawtooth repeat, 2 = triangle, 3 = reserved (rejected).
- cfg_err  out  1  one-cycle pulse when a configuration is rejected.
- start  in  1  begin a sweep using the latched configuration.
- abort  in  1  stop immediately.
- fre_dat  out  FW  frequency word to the DDS.
- fre_upd  out  1  one-cycle pulse in every cycle in which a new period of fre_dat begins.
- dds_en  out  1  DDS output enable.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at the end of a single-shot sweep.

Behaviour:
- Reset (async, rst=1):
  - fre_dat=0, fre_upd=0, dds_en=0, busy=0, done=0, cfg_err=0.
  - Shadow configuration cleared, state=IDLE, dir=UP.
- States: IDLE, RUN.
  - busy=1 exactly in RUN.
  - cfg_ready=1 exactly in IDLE.
- Configuration acceptance (in IDLE, when cfg_valid=1):
  - Rejected, with cfg_err pulsing the next cycle and shadow registers unchanged, if cfg_step==0, cfg_start>cfg_stop, or cfg_mode==3.
  - Otherwise all fields are latched into the shadow registers simultaneously.
  - A shadow-valid flag is set on acceptance.
  - cfg_valid outside IDLE is ignored; no error is flagged.
- Start:
  - Takes effect only in IDLE with shadow-valid=1; otherwise it is ignored.
  - It uses the shadow contents as of the previous cycle. A cfg_valid in the same cycle is still accepted, but applies to the next sweep.
- Sweep start timing, for start sampled in cycle t:
  - At t+1: state=RUN, fre_dat=start, fre_upd=1, dds_en=1, dir=UP, dwell counter=cfg_dwell.
- Dwell rule:
  - Every frequency value is held exactly cfg_dwell+1 cycles.
  - In RUN the counter decrements each cycle. When it reads 0, the next period begins in the following cycle: fre_dat updates, fre_upd=1, counter reloads.
- Step arithmetic:
  - Computed at FW+1 bits to catch overflow and underflow.
  - UP: nxt = cur + step. If nxt ≥ stop or a carry occurs, fre_dat = stop (clamped).
  - DOWN: nxt = cur − step. If a borrow occurs or nxt ≤ start, fre_dat = start (clamped).
- End of the period at stop (dir=UP):
  - Mode 0: return to IDLE and pulse done in that cycle. fre_dat holds stop and dds_en stays 1.
  - Mode 1: the next period is start.
  - Mode 2: dir=DOWN, and the next value is stop−step (clamped).
- End of the period at start with dir=DOWN (mode 2): dir=UP, and the next value is start+step (clamped).
- start==stop:
  - Mode 0: one period, then done.
  - Modes 1 and 2: fre_upd still pulses every cfg_dwell+1 cycles with an unchanged value.
- Abort:
  - Highest priority, in any state.
  - Next cycle: IDLE, dds_en=0, busy=0, no done pulse. fre_dat retains its value.
- start while in RUN is ignored. A new start from IDLE after done restarts cleanly from the start frequency.
- Reset mid-sweep forces all reset values immediately; the shadow configuration is lost.

Decomposition:
- Shared package dds_ctrl_pkg:
  - Mode encodings MODE_SINGLE=0, MODE_SAW=1, MODE_TRI=2.
  - State encodings for IDLE and RUN, and direction encodings for UP and DOWN.
  - Default widths FW=24 and DW=16.
- One sub-module, dds_dwell_timer:
  - Loadable DW-bit down-counter with a load input and an expire output.
  - Instantiated once. The step and clamp logic stays in the parent.

Test Plan:
- Mode 0, start=100, stop=130, step=10, dwell=2 -> fre_dat 100, 110, 120, 130, each held 3 cycles. fre_upd pulses 4 times. done pulses once, 12 cycles after the first update. busy falls and dds_en stays 1.
- Mode 0, start=0, stop=25, step=10, dwell=0 -> sequence 0, 10, 20, 25 (clamped), then done.
- Mode 2, start=100, stop=120, step=10, dwell=0 -> 100, 110, 120, 110, 100, 110, 120, … with no done pulse. Mode 1 with the same values -> 100, 110, 120, 100, ….
- Overflow: start=0xFFFFF0, stop=0xFFFFFF, step=0x20, mode 0 -> 0xFFFFF0, then 0xFFFFFF, then done. The value never wraps to a small number.
- Abort asserted on the 5th cycle of the first test -> next cycle busy=0 and dds_en=0, fre_dat frozen at 110, no done pulse. A subsequent start reproduces the full sequence.
- Invalid configuration (start=200, stop=100; or step=0; or mode=3) -> cfg_err pulses once and the previous shadow configuration is kept. start in IDLE with no valid configuration since reset -> ignored, busy stays 0.
